uart_trx_param: RTL and testbench

// Parametrised full-duplex UART: a TX serialiser plus an oversampled RX deserialiser sharing one baud-tick generator.

---
 rtl/uart_trx_param_pkg.sv | 33 +++
 rtl/uart_baud_gen.sv | 22 ++
 rtl/uart_trx_param.sv | 209 ++++++++++++++++++++
 tb/tb_uart_trx_param.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_trx_param_pkg.sv
// Shared definitions for the parametrised UART: parity modes, FSM state
// encodings and the baud-tick divisor calculation.
package uart_trx_param_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_t;

  // Clocks per oversample tick, never below one.
  function automatic int tick_div(input int clk_freq, input int baud_rate,
                                  input int oversample);
    int d;
    d = clk_freq / (baud_rate * oversample);
    return (d < 1) ? 1 : d;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Free-running divider producing a one-cycle tick every DIV clocks.
module uart_baud_gen #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst || tick) cnt <= '0;
    else             cnt <= cnt + CW'(1);
  end

endmodule

// File: rtl/uart_trx_param.sv
// Full-duplex UART: TX serialiser and oversampled RX deserialiser sharing one
// baud-tick generator, with valid/ready handshakes and internal loopback.
module uart_trx_param
  import uart_trx_param_pkg::*;
#(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD_RATE  = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx_busy,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_frame_err,
  output logic                 rx_parity_err,
  output logic                 rx_overrun,
  input  logic                 loopback,
  input  logic                 Rx,
  output logic                 Tx
);

  localparam int TICK_DIV = tick_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
  localparam int TW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [TW-1:0] BIT_LAST  = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);
  localparam bit            HAS_PAR   = (PARITY != PAR_NONE);
  localparam logic          ODD_SEED  = (PARITY == PAR_ODD);

  logic tick;

  uart_baud_gen #(.DIV(TICK_DIV)) u_baud (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  // ---------------- transmitter ----------------
  tx_state_t            tx_state, tx_state_n;
  logic [TW-1:0]        tx_tick;
  logic [3:0]           tx_bit;
  logic [DATA_BITS-1:0] tx_shreg;
  logic                 tx_par;
  logic                 tx_line;
  logic                 tx_bit_end;

  assign tx_ready   = (tx_state == TX_IDLE);
  assign tx_busy    = ~tx_ready;
  assign tx_bit_end = tick & (tx_tick == BIT_LAST);
  assign Tx         = tx_line | loopback;

  always_comb begin
    tx_state_n = tx_state;
    tx_line    = 1'b1;
    case (tx_state)
      TX_IDLE:   if (tx_valid) tx_state_n = TX_START;
      TX_START: begin
        tx_line = 1'b0;
        if (tx_bit_end) tx_state_n = TX_DATA;
      end
      TX_DATA: begin
        tx_line = tx_shreg[0];
        if (tx_bit_end && tx_bit == DATA_LAST)
          tx_state_n = HAS_PAR ? TX_PARITY : TX_STOP;
      end
      TX_PARITY: begin
        tx_line = tx_par;
        if (tx_bit_end) tx_state_n = TX_STOP;
      end
      TX_STOP:   if (tx_bit_end && tx_bit == STOP_LAST) tx_state_n = TX_IDLE;
      default:   tx_state_n = TX_IDLE;
    endcase
  end

  // Tick and bit counters restart on every state change.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state <= TX_IDLE;
      tx_tick  <= '0;
      tx_bit   <= '0;
    end else begin
      tx_state <= tx_state_n;
      if (tx_state_n != tx_state) begin
        tx_tick <= '0;
        tx_bit  <= '0;
      end else if (tx_bit_end) begin
        tx_tick <= '0;
        tx_bit  <= tx_bit + 4'd1;
      end else if (tick && tx_state != TX_IDLE) begin
        tx_tick <= tx_tick + TW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (tx_valid && tx_ready) begin
      tx_shreg <= tx_data;
      tx_par   <= (^tx_data) ^ ODD_SEED;
    end else if (tx_state == TX_DATA && tx_bit_end) begin
      tx_shreg <= tx_shreg >> 1;
    end
  end

  // ---------------- receiver ----------------
  logic                 rx_sync_p0, rx_sync_p1, rx_prev;
  rx_state_t            rx_state, rx_state_n;
  logic [TW-1:0]        rx_tick;
  logic [3:0]           rx_bit;
  logic [DATA_BITS-1:0] rx_shreg;
  logic                 rx_par;
  logic                 rx_samp, rx_done, rx_par_bad;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_sync_p0 <= 1'b1;
      rx_sync_p1 <= 1'b1;
      rx_prev    <= 1'b1;
    end else begin
      rx_sync_p0 <= loopback ? tx_line : Rx;
      rx_sync_p1 <= rx_sync_p0;
      rx_prev    <= rx_sync_p1;
    end
  end

  // The start bit is checked at half a bit; everything after at full-bit steps.
  assign rx_samp    = tick & (rx_tick == ((rx_state == RX_START) ? HALF_LAST : BIT_LAST));
  assign rx_par_bad = HAS_PAR && (((^rx_shreg) ^ rx_par) != ODD_SEED);

  always_comb begin
    rx_state_n = rx_state;
    rx_done    = 1'b0;
    case (rx_state)
      RX_IDLE:   if (rx_prev && !rx_sync_p1) rx_state_n = RX_START;
      RX_START:  if (rx_samp) rx_state_n = rx_sync_p1 ? RX_IDLE : RX_DATA;
      RX_DATA:   if (rx_samp && rx_bit == DATA_LAST)
                   rx_state_n = HAS_PAR ? RX_PARITY : RX_STOP;
      RX_PARITY: if (rx_samp) rx_state_n = RX_STOP;
      RX_STOP: begin
        if (rx_samp) begin
          rx_state_n = RX_IDLE;
          rx_done    = 1'b1;
        end
      end
      default:   rx_state_n = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state <= RX_IDLE;
      rx_tick  <= '0;
      rx_bit   <= '0;
    end else begin
      rx_state <= rx_state_n;
      if (rx_state_n != rx_state) begin
        rx_tick <= '0;
        rx_bit  <= '0;
      end else if (rx_samp) begin
        rx_tick <= '0;
        rx_bit  <= rx_bit + 4'd1;
      end else if (tick && rx_state != RX_IDLE) begin
        rx_tick <= rx_tick + TW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rx_state == RX_DATA && rx_samp)
      rx_shreg <= {rx_sync_p1, rx_shreg[DATA_BITS-1:1]};
    if (rx_state == RX_PARITY && rx_samp)
      rx_par <= rx_sync_p1;
  end

  // A handshake in the same cycle as frame end lets the new frame replace the old one.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_valid      <= 1'b0;
      rx_data       <= '0;
      rx_frame_err  <= 1'b0;
      rx_parity_err <= 1'b0;
      rx_overrun    <= 1'b0;
    end else begin
      if (rx_valid && rx_ready) begin
        rx_valid   <= 1'b0;
        rx_overrun <= 1'b0;
      end
      if (rx_done) begin
        if (!rx_valid || rx_ready) begin
          rx_valid      <= 1'b1;
          rx_data       <= rx_shreg;
          rx_frame_err  <= ~rx_sync_p1;
          rx_parity_err <= rx_par_bad;
        end else begin
          rx_overrun <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_trx_param.sv
// Directed bench for uart_trx_param: an 8N1 instance and an 8E2 instance,
// both at one tick per clock and 16 clocks per bit.
`timescale 1ns/1ps
module tb_uart_trx_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  // 8N1 instance
  logic [7:0] tx_data_n, rx_data_n;
  logic tx_valid_n, tx_ready_n, tx_busy_n, rx_valid_n, rx_ready_n;
  logic ferr_n, perr_n, ovr_n, loopback_n, rx_n, tx_n;
  logic ext_loop, rx_drv_n;
  assign rx_n = ext_loop ? tx_n : rx_drv_n;

  uart_trx_param #(.CLK_FREQ(1600000), .BAUD_RATE(100000), .OVERSAMPLE(16),
                   .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut_n (
    .clk(clk), .rst(rst), .tx_data(tx_data_n), .tx_valid(tx_valid_n),
    .tx_ready(tx_ready_n), .tx_busy(tx_busy_n), .rx_data(rx_data_n),
    .rx_valid(rx_valid_n), .rx_ready(rx_ready_n), .rx_frame_err(ferr_n),
    .rx_parity_err(perr_n), .rx_overrun(ovr_n), .loopback(loopback_n),
    .Rx(rx_n), .Tx(tx_n));

  // 8E2 instance, Rx wired back to its own Tx pin
  logic [7:0] tx_data_e, rx_data_e;
  logic tx_valid_e, tx_ready_e, tx_busy_e, rx_valid_e, rx_ready_e;
  logic ferr_e, perr_e, ovr_e, loopback_e, rx_e, tx_e;
  assign rx_e = tx_e;

  uart_trx_param #(.CLK_FREQ(1600000), .BAUD_RATE(100000), .OVERSAMPLE(16),
                   .DATA_BITS(8), .PARITY(2), .STOP_BITS(2)) dut_e (
    .clk(clk), .rst(rst), .tx_data(tx_data_e), .tx_valid(tx_valid_e),
    .tx_ready(tx_ready_e), .tx_busy(tx_busy_e), .rx_data(rx_data_e),
    .rx_valid(rx_valid_e), .rx_ready(rx_ready_e), .rx_frame_err(ferr_e),
    .rx_parity_err(perr_e), .rx_overrun(ovr_e), .loopback(loopback_e),
    .Rx(rx_e), .Tx(tx_e));

  task automatic send_n(input logic [7:0] d);
    for (int g = 0; g < 400 && !tx_ready_n; g++) begin
      @(posedge clk); #1;
    end
    tx_data_n = d; tx_valid_n = 1'b1;
    @(posedge clk); #1;
    tx_valid_n = 1'b0;
  endtask

  task automatic wait_rx_n(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (rx_valid_n) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic consume_n();
    rx_ready_n = 1'b1;
    @(posedge clk); #1;
    rx_ready_n = 1'b0;
  endtask

  task automatic line_bit(input logic v);
    rx_drv_n = v;
    repeat (16) @(posedge clk);
    #1;
  endtask

  task automatic drive_frame_n(input logic [7:0] d, input logic stop);
    line_bit(1'b0);
    for (int i = 0; i < 8; i++) line_bit(d[i]);
    line_bit(stop);
    line_bit(1'b1);
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_tests++; if (tx_n !== 1'b1) begin n_fail++; $display("FAIL reset_tx: got %b expected 1", tx_n); end
    n_tests++; if (tx_ready_n !== 1'b1) begin n_fail++; $display("FAIL reset_tx_ready: got %b expected 1", tx_ready_n); end
    n_tests++; if (tx_busy_n !== 1'b0) begin n_fail++; $display("FAIL reset_tx_busy: got %b expected 0", tx_busy_n); end
    n_tests++; if ({rx_valid_n, rx_data_n} !== 9'h000) begin n_fail++; $display("FAIL reset_rx: got %h expected 000", {rx_valid_n, rx_data_n}); end
    n_tests++; if ({ferr_n, perr_n, ovr_n} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b expected 000", {ferr_n, perr_n, ovr_n}); end
    n_tests++; if ({tx_e, tx_ready_e, rx_valid_e} !== 3'b110) begin n_fail++; $display("FAIL reset_8e2: got %b expected 110", {tx_e, tx_ready_e, rx_valid_e}); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_loopback_8n1();
    logic [9:0] pat;
    bit seen;
    pat = 10'b1101001010;
    loopback_n = 1'b1; ext_loop = 1'b0;
    send_n(8'hA5);
    repeat (8) @(posedge clk);
    #1;
    n_tests++; if (tx_n !== 1'b1) begin n_fail++; $display("FAIL lb_pin_high: got %b expected 1", tx_n); end
    wait_rx_n(400, seen);
    n_tests++; if (!seen) begin n_fail++; $display("FAIL lb_rx_valid: got 0 expected 1"); end
    n_tests++; if (rx_data_n !== 8'hA5) begin n_fail++; $display("FAIL lb_rx_data: got %h expected a5", rx_data_n); end
    n_tests++; if ({ferr_n, perr_n, ovr_n} !== 3'b000) begin n_fail++; $display("FAIL lb_flags: got %b expected 000", {ferr_n, perr_n, ovr_n}); end
    consume_n();
    n_tests++; if (rx_valid_n !== 1'b0) begin n_fail++; $display("FAIL lb_consume: got %b expected 0", rx_valid_n); end

    loopback_n = 1'b0; ext_loop = 1'b1;
    send_n(8'hA5);
    for (int k = 0; k < 10; k++) begin
      repeat (k == 0 ? 8 : 16) @(posedge clk);
      #1;
      n_tests++; if (tx_n !== pat[k]) begin n_fail++; $display("FAIL tx_bit%0d: got %b expected %b", k, tx_n, pat[k]); end
    end
    wait_rx_n(100, seen);
    n_tests++; if (!seen || rx_data_n !== 8'hA5) begin n_fail++; $display("FAIL ext_rx_data: got %b/%h expected 1/a5", seen, rx_data_n); end
    consume_n();
  endtask

  task automatic test_8e2();
    loopback_e = 1'b0;
    tx_data_e = 8'h07; tx_valid_e = 1'b1;
    @(posedge clk); #1;
    tx_valid_e = 1'b0;
    for (int c = 1; c <= 192; c++) begin
      @(posedge clk); #1;
      if (c == 1) begin
        n_tests++; if ({tx_busy_e, tx_ready_e} !== 2'b10) begin n_fail++; $display("FAIL e_busy: got %b expected 10", {tx_busy_e, tx_ready_e}); end
      end
      if (c == 136) begin
        n_tests++; if (tx_e !== 1'b0) begin n_fail++; $display("FAIL e_bit7: got %b expected 0", tx_e); end
      end
      if (c == 152) begin
        n_tests++; if (tx_e !== 1'b1) begin n_fail++; $display("FAIL e_parity: got %b expected 1", tx_e); end
      end
      if (c == 184) begin
        n_tests++; if (tx_e !== 1'b1) begin n_fail++; $display("FAIL e_stop2: got %b expected 1", tx_e); end
      end
      if (c == 191) begin
        n_tests++; if (tx_ready_e !== 1'b0) begin n_fail++; $display("FAIL e_ready_early: got %b expected 0", tx_ready_e); end
      end
    end
    n_tests++; if (tx_ready_e !== 1'b1) begin n_fail++; $display("FAIL e_ready_192: got %b expected 1", tx_ready_e); end
    n_tests++; if ({rx_valid_e, rx_data_e, perr_e, ferr_e} !== 11'b1_00000111_0_0) begin n_fail++; $display("FAIL e_rx_07: got %b expected 10000011100", {rx_valid_e, rx_data_e, perr_e, ferr_e}); end
    // Back-to-back frame 0x03 (even parity bit 0), consuming 0x07 on the same edge.
    tx_data_e = 8'h03; tx_valid_e = 1'b1; rx_ready_e = 1'b1;
    @(posedge clk); #1;
    tx_valid_e = 1'b0; rx_ready_e = 1'b0;
    n_tests++; if ({rx_valid_e, tx_busy_e} !== 2'b01) begin n_fail++; $display("FAIL e_b2b: got %b expected 01", {rx_valid_e, tx_busy_e}); end
    for (int c = 2; c <= 192; c++) begin
      @(posedge clk); #1;
      if (c == 152) begin
        n_tests++; if (tx_e !== 1'b0) begin n_fail++; $display("FAIL e_parity0: got %b expected 0", tx_e); end
      end
    end
    n_tests++; if ({rx_valid_e, rx_data_e, perr_e, ferr_e} !== 11'b1_00000011_0_0) begin n_fail++; $display("FAIL e_rx_03: got %b expected 10000001100", {rx_valid_e, rx_data_e, perr_e, ferr_e}); end
  endtask

  task automatic test_frame_err();
    bit seen;
    loopback_n = 1'b0; ext_loop = 1'b0; rx_drv_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    drive_frame_n(8'h3C, 1'b0);
    wait_rx_n(40, seen);
    n_tests++; if (!seen || rx_data_n !== 8'h3C) begin n_fail++; $display("FAIL ferr_data: got %b/%h expected 1/3c", seen, rx_data_n); end
    n_tests++; if ({ferr_n, perr_n} !== 2'b10) begin n_fail++; $display("FAIL ferr_flag: got %b expected 10", {ferr_n, perr_n}); end
    consume_n();
    drive_frame_n(8'h81, 1'b1);
    wait_rx_n(40, seen);
    n_tests++; if (!seen || rx_data_n !== 8'h81 || ferr_n !== 1'b0) begin n_fail++; $display("FAIL ferr_clear: got %b/%h/%b expected 1/81/0", seen, rx_data_n, ferr_n); end
    consume_n();
  endtask

  task automatic test_overrun();
    drive_frame_n(8'h11, 1'b1);
    drive_frame_n(8'h22, 1'b1);
    n_tests++; if ({rx_valid_n, rx_data_n, ovr_n} !== 10'b1_00010001_1) begin n_fail++; $display("FAIL ovr_set: got %b expected 1000100011", {rx_valid_n, rx_data_n, ovr_n}); end
    consume_n();
    n_tests++; if ({rx_valid_n, ovr_n} !== 2'b00) begin n_fail++; $display("FAIL ovr_clear: got %b expected 00", {rx_valid_n, ovr_n}); end
  endtask

  task automatic test_glitch();
    bit seen;
    rx_drv_n = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rx_drv_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    n_tests++; if ({rx_valid_n, ferr_n} !== 2'b00) begin n_fail++; $display("FAIL glitch: got %b expected 00", {rx_valid_n, ferr_n}); end
    drive_frame_n(8'h96, 1'b1);
    wait_rx_n(40, seen);
    n_tests++; if (!seen || rx_data_n !== 8'h96) begin n_fail++; $display("FAIL glitch_next: got %b/%h expected 1/96", seen, rx_data_n); end
    consume_n();
  endtask

  task automatic test_reset_mid();
    bit seen;
    ext_loop = 1'b1; loopback_n = 1'b0;
    send_n(8'hC3);
    wait_rx_n(400, seen);
    n_tests++; if (!seen || rx_data_n !== 8'hC3) begin n_fail++; $display("FAIL rm_pending: got %b/%h expected 1/c3", seen, rx_data_n); end
    send_n(8'h00);
    repeat (40) @(posedge clk);
    #1;
    n_tests++; if ({tx_n, tx_busy_n} !== 2'b01) begin n_fail++; $display("FAIL rm_inflight: got %b expected 01", {tx_n, tx_busy_n}); end
    rst = 1'b1;
    @(posedge clk); #1;
    n_tests++; if ({tx_n, tx_ready_n, tx_busy_n} !== 3'b110) begin n_fail++; $display("FAIL rm_tx: got %b expected 110", {tx_n, tx_ready_n, tx_busy_n}); end
    n_tests++; if ({rx_valid_n, rx_data_n, ferr_n, perr_n, ovr_n} !== 12'h000) begin n_fail++; $display("FAIL rm_rx: got %h expected 000", {rx_valid_n, rx_data_n, ferr_n, perr_n, ovr_n}); end
    rst = 1'b0;
    @(posedge clk); #1;
    send_n(8'h5A);
    wait_rx_n(400, seen);
    n_tests++; if (!seen || rx_data_n !== 8'h5A) begin n_fail++; $display("FAIL rm_after: got %b/%h expected 1/5a", seen, rx_data_n); end
    n_tests++; if ({ferr_n, perr_n, ovr_n} !== 3'b000) begin n_fail++; $display("FAIL rm_after_flags: got %b expected 000", {ferr_n, perr_n, ovr_n}); end
    consume_n();
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    tx_data_n = '0; tx_valid_n = 1'b0; rx_ready_n = 1'b0; loopback_n = 1'b0;
    ext_loop = 1'b0; rx_drv_n = 1'b1;
    tx_data_e = '0; tx_valid_e = 1'b0; rx_ready_e = 1'b0; loopback_e = 1'b0;
    test_reset();
    test_loopback_8n1();
    test_8e2();
    test_frame_err();
    test_overrun();
    test_glitch();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
